fib_stack: RTL and testbench

- LIFO data stack for the recursive Fibonacci datapath; consumes the stack controller's push/pop/pushSrc strobes.
- Push stores one of three frame words: flag, n or return value.
- The top-of-stack word is presented combinationally, so the flag/n/result registers capture it on the same edge as the pop.
- Provides occupancy, full/empty, high-water mark and sticky error flags for the top-level controller and debug.

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_stack_ram.sv | 24 ++
 rtl/fib_stack.sv | 113 +++++++++++
 tb/tb_fib_stack.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared constants for the recursive Fibonacci datapath: push source codes
// and default stack geometry.
package fib_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 32;

  typedef enum logic [1:0] {
    SRC_FLAG = 2'd0,
    SRC_N    = 2'd1,
    SRC_RET  = 2'd2,
    SRC_ZERO = 2'd3
  } src_t;

endpackage

// File: rtl/fib_stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy tracking masks stale words.
module fib_stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fib_stack.sv
// LIFO frame stack for the recursive Fibonacci controller, with occupancy,
// high-water mark and sticky overflow/underflow reporting.
module fib_stack
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [1:0]       pushSrc,
  input  logic [WIDTH-1:0] flagIn,
  input  logic [WIDTH-1:0] nIn,
  input  logic [WIDTH-1:0] retIn,
  input  logic             clrErr,
  output logic [WIDTH-1:0] top,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [AW:0]      maxDepth
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Strobe semantics: push/pop are single-cycle commands with no ready
  // handshake; a command that cannot complete (push when full, pop when
  // empty) leaves the stack untouched and raises the matching sticky flag.
  logic [AW:0]      cnt_q, cnt_next, max_q;
  logic             ovf_q, udf_q, ovf_set, udf_set;
  logic             wr_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [WIDTH-1:0] wr_data, rd_data;
  logic             is_empty, is_full;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == DEPTH_C);
  assign rd_addr  = cnt_q[AW-1:0] - 1'b1;

  always_comb begin
    wr_data = '0;
    case (pushSrc)
      SRC_FLAG: wr_data = flagIn;
      SRC_N:    wr_data = nIn;
      SRC_RET:  wr_data = retIn;
      default:  wr_data = '0;
    endcase
  end

  always_comb begin
    cnt_next = cnt_q;
    wr_en    = 1'b0;
    wr_addr  = cnt_q[AW-1:0];
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    if (push && pop) begin
      // Simultaneous push+pop replaces the top; on an empty stack it degrades to a push.
      wr_en = 1'b1;
      if (is_empty) cnt_next = cnt_q + 1'b1;
      else          wr_addr  = rd_addr;
    end else if (push) begin
      if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en    = 1'b1;
        cnt_next = cnt_q + 1'b1;
      end
    end else if (pop) begin
      if (is_empty) udf_set  = 1'b1;
      else          cnt_next = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      max_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      max_q <= (cnt_next > max_q) ? cnt_next : max_q;
      ovf_q <= ovf_set | (ovf_q & ~clrErr);
      udf_q <= udf_set | (udf_q & ~clrErr);
    end
  end

  fib_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign top       = is_empty ? '0 : rd_data;
  assign count     = cnt_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign maxDepth  = max_q;

endmodule

// File: tb/tb_fib_stack.sv
// Directed bench for fib_stack: the driver queues expected observations,
// a negedge monitor pops and compares them against the live outputs.
module tb_fib_stack;
  import fib_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [3:0] O_TOP = 4'd0, O_CNT = 4'd1, O_EMP = 4'd2, O_FUL = 4'd3,
                         O_OVF = 4'd4, O_UDF = 4'd5, O_MAX = 4'd6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             push, pop, clrErr;
  logic [1:0]       pushSrc;
  logic [WIDTH-1:0] flagIn, nIn, retIn;
  logic [WIDTH-1:0] top;
  logic [AW:0]      count, maxDepth;
  logic             empty, full, overflow, underflow;

  // Each entry: {observable select, expected value}
  logic [19:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  fib_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .pushSrc   (pushSrc),
    .flagIn    (flagIn),
    .nIn       (nIn),
    .retIn     (retIn),
    .clrErr    (clrErr),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .maxDepth  (maxDepth)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive(input logic p, input logic q, input logic [1:0] s, input logic c);
    push = p; pop = q; pushSrc = s; clrErr = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clrErr = 1'b0; pushSrc = 2'd0;
  endtask

  task automatic expect_obs(input logic [3:0] sel, input logic [15:0] val);
    exp_q.push_back({sel, val});
  endtask

  task automatic expect_state(input logic [15:0] t, input logic [15:0] c,
                              input logic e, input logic f);
    expect_obs(O_TOP, t);
    expect_obs(O_CNT, c);
    expect_obs(O_EMP, 16'(e));
    expect_obs(O_FUL, 16'(f));
  endtask

  // Scoreboard monitor
  function automatic logic [15:0] observe(input logic [3:0] sel);
    case (sel)
      O_TOP:   return top;
      O_CNT:   return 16'(count);
      O_EMP:   return 16'(empty);
      O_FUL:   return 16'(full);
      O_OVF:   return 16'(overflow);
      O_UDF:   return 16'(underflow);
      default: return 16'(maxDepth);
    endcase
  endfunction

  function automatic string obs_name(input logic [3:0] sel);
    case (sel)
      O_TOP:   return "top";
      O_CNT:   return "count";
      O_EMP:   return "empty";
      O_FUL:   return "full";
      O_OVF:   return "overflow";
      O_UDF:   return "underflow";
      default: return "maxDepth";
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [19:0] e;
      logic [15:0] act;
      e   = exp_q.pop_front();
      act = observe(e[19:16]);
      n_checks++;
      if (act !== e[15:0]) begin
        n_fail++;
        $display("FAIL %s @%0t: act=0x%0h exp=0x%0h", obs_name(e[19:16]), $time, act, e[15:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; clrErr = 1'b0; pushSrc = 2'd0;
    flagIn = '0; nIn = '0; retIn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset / idle
    expect_state(16'h0, 16'd0, 1'b1, 1'b0);
    expect_obs(O_OVF, 16'd0);
    expect_obs(O_UDF, 16'd0);
    expect_obs(O_MAX, 16'd0);

    // One frame: flag, ret, n
    flagIn = 16'd1; retIn = 16'd7; nIn = 16'd5;
    drive(1'b1, 1'b0, SRC_FLAG, 1'b0);
    expect_state(16'd1, 16'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, SRC_RET, 1'b0);
    drive(1'b1, 1'b0, SRC_N, 1'b0);
    expect_state(16'd5, 16'd3, 1'b0, 1'b0);
    expect_obs(O_MAX, 16'd3);

    // Pop it back; top shows the next-lower word after each edge
    drive(1'b0, 1'b1, SRC_FLAG, 1'b0);
    expect_obs(O_TOP, 16'd7);
    drive(1'b0, 1'b1, SRC_FLAG, 1'b0);
    expect_obs(O_TOP, 16'd1);
    drive(1'b0, 1'b1, SRC_FLAG, 1'b0);
    expect_state(16'd0, 16'd0, 1'b1, 1'b0);
    expect_obs(O_MAX, 16'd3);

    // Fill to DEPTH, then one push too many
    nIn = 16'h00A5;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, SRC_N, 1'b0);
    expect_state(16'h00A5, 16'(DEPTH), 1'b0, 1'b1);
    expect_obs(O_OVF, 16'd0);
    nIn = 16'h005A;
    drive(1'b1, 1'b0, SRC_N, 1'b0);
    expect_state(16'h00A5, 16'(DEPTH), 1'b0, 1'b1);
    expect_obs(O_OVF, 16'd1);
    expect_obs(O_MAX, 16'(DEPTH));
    drive(1'b0, 1'b0, SRC_FLAG, 1'b1);
    expect_obs(O_OVF, 16'd0);

    // Drain, then underflow; error in the same cycle as clrErr keeps the flag
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, SRC_FLAG, 1'b0);
    expect_state(16'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, SRC_FLAG, 1'b0);
    expect_state(16'd0, 16'd0, 1'b1, 1'b0);
    expect_obs(O_UDF, 16'd1);
    drive(1'b0, 1'b1, SRC_FLAG, 1'b1);
    expect_obs(O_UDF, 16'd1);
    drive(1'b0, 1'b0, SRC_FLAG, 1'b1);
    expect_obs(O_UDF, 16'd0);

    // Push+pop on empty acts as push; on non-empty it replaces the top
    retIn = 16'd9;
    drive(1'b1, 1'b1, SRC_RET, 1'b0);
    expect_state(16'd9, 16'd1, 1'b0, 1'b0);
    expect_obs(O_UDF, 16'd0);
    nIn = 16'd4;
    drive(1'b1, 1'b1, SRC_N, 1'b0);
    expect_state(16'd4, 16'd1, 1'b0, 1'b0);

    // Zero source pushes an all-zero word
    nIn = 16'hFFFF;
    drive(1'b1, 1'b0, SRC_ZERO, 1'b0);
    expect_state(16'd0, 16'd2, 1'b0, 1'b0);
    expect_obs(O_OVF, 16'd0);
    drive(1'b0, 1'b1, SRC_FLAG, 1'b0);
    expect_state(16'd4, 16'd1, 1'b0, 1'b0);

    // Two more words, then async reset mid-cycle (checked before any edge)
    drive(1'b1, 1'b0, SRC_N, 1'b0);
    drive(1'b1, 1'b0, SRC_N, 1'b0);
    expect_obs(O_CNT, 16'd3);
    @(posedge clk);
    #1;
    expect_state(16'd0, 16'd0, 1'b1, 1'b0);
    expect_obs(O_MAX, 16'd0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_state(16'd0, 16'd0, 1'b1, 1'b0);

    // Final report
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: act=%0d pending exp=0 pending", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
